// File: rtl/hir_mem_pkg.sv
// Shared types and default widths for the HIR memory responder.
package hir_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 7;

endpackage

// File: rtl/hir_mem_array.sv
// Register-file memory: three registered read ports and two write ports,
// where write port A (kernel) overrides write port B (host) on the same address.
module hir_mem_array
  import hir_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 128
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [2:0]                    rd_en,
  input  logic [2:0][ADDR_W-1:0]        rd_addr,
  output logic [2:0][DATA_W-1:0]        rd_data,
  input  logic                          wa_en,
  input  logic [ADDR_W-1:0]             wa_addr,
  input  logic [DATA_W-1:0]             wa_data,
  input  logic                          wb_en,
  input  logic [ADDR_W-1:0]             wb_addr,
  input  logic [DATA_W-1:0]             wb_data
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  // Port A is written last so it takes precedence when both hit one word.
  always_ff @(posedge clk) begin
    if (wb_en && in_range(wb_addr)) mem[wb_addr] <= wb_data;
    if (wa_en && in_range(wa_addr)) mem[wa_addr] <= wa_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rd
      logic [DATA_W-1:0] rd_data_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rd_data_reg <= '0;
        end else if (rd_en[gi]) begin
          rd_data_reg <= in_range(rd_addr[gi]) ? mem[rd_addr[gi]] : '0;
        end
      end

      assign rd_data[gi] = rd_data_reg;
    end
  endgenerate

endmodule

// File: rtl/hir_mem_responder.sv
// Memory-side responder for HIR kernels: two kernel read ports, one kernel write
// port, a host load/dump port, and a run tracker that pulses done at the last write.
module hir_mem_responder
  import hir_mem_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DEPTH           = 128,
  parameter int EXPECTED_WRITES = 128
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tstart,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic              rd0_en,
  output logic [DATA_W-1:0] rd0_data,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic              rd1_en,
  output logic [DATA_W-1:0] rd1_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              done
);

  localparam logic [15:0] WR_TARGET = 16'(EXPECTED_WRITES);

  state_t                  state_reg, state_next;
  logic [15:0]             wr_cnt_reg, wr_cnt_next;
  logic [15:0]             wr_cnt_inc;
  logic                    host_rvalid_reg;
  logic                    host_acc, host_rd_acc, host_wr_acc;
  logic [2:0][DATA_W-1:0]  rd_data_all;

  assign host_acc    = host_valid & host_ready;
  assign host_rd_acc = host_acc & ~host_we;
  assign host_wr_acc = host_acc & host_we;
  assign wr_cnt_inc  = wr_cnt_reg + 16'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      wr_cnt_reg      <= '0;
      host_rvalid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_cnt_reg      <= wr_cnt_next;
      host_rvalid_reg <= host_rd_acc;
    end
  end

  // The host port is only open in IDLE so preload/dump never races a kernel run.
  always_comb begin
    state_next  = state_reg;
    wr_cnt_next = wr_cnt_reg;
    host_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        host_ready = 1'b1;
        if (tstart) begin
          state_next  = RUN;
          wr_cnt_next = '0;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (wr_en) begin
          wr_cnt_next = wr_cnt_inc;
          if (wr_cnt_inc == WR_TARGET) state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  hir_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rstn    (rstn),
    .rd_en   ({host_rd_acc, rd1_en, rd0_en}),
    .rd_addr ({host_addr, rd1_addr, rd0_addr}),
    .rd_data (rd_data_all),
    .wa_en   (wr_en),
    .wa_addr (wr_addr),
    .wa_data (wr_data),
    .wb_en   (host_wr_acc),
    .wb_addr (host_addr),
    .wb_data (host_wdata)
  );

  assign rd0_data    = rd_data_all[0];
  assign rd1_data    = rd_data_all[1];
  assign host_rdata  = rd_data_all[2];
  assign host_rvalid = host_rvalid_reg;

endmodule

// File: tb/tb_hir_mem_responder.sv
// Scoreboard bench for hir_mem_responder with a small depth and a 4-write run.
module tb_hir_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 100;
  localparam int EW    = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          tstart = 1'b0;
  logic [AW-1:0] rd0_addr = '0, rd1_addr = '0, wr_addr = '0, host_addr = '0;
  logic          rd0_en = 1'b0, rd1_en = 1'b0, wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0, host_wdata = '0;
  logic          host_valid = 1'b0, host_we = 1'b0;
  logic [DW-1:0] rd0_data, rd1_data, host_rdata;
  logic          host_ready, host_rvalid, busy, done;

  always #5 clk = ~clk;

  hir_mem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .EXPECTED_WRITES(EW)
  ) dut (
    .clk(clk), .rstn(rstn), .tstart(tstart),
    .rd0_addr(rd0_addr), .rd0_en(rd0_en), .rd0_data(rd0_data),
    .rd1_addr(rd1_addr), .rd1_en(rd1_en), .rd1_data(rd1_data),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .busy(busy), .done(done)
  );

  typedef enum {M_IDLE, M_RUN, M_DRAIN} mst_t;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] model_mem [DEPTH];
  mst_t          mst = M_IDLE;
  int            mcnt = 0;
  logic [DW-1:0] rd0_q[$], rd1_q[$], host_q[$];
  logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0, exp_hrd = '0;
  bit            last_hacc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) ? model_mem[a] : '0;
  endfunction

  task automatic idle_inputs();
    tstart = 0; rd0_en = 0; rd1_en = 0; wr_en = 0; host_valid = 0; host_we = 0;
  endtask

  // One clock: record expectations from the model, let the edge pass, then compare.
  task automatic step();
    bit hacc, hrd;
    hacc = host_valid && (mst == M_IDLE);
    hrd  = hacc && !host_we;
    if (rd0_en) rd0_q.push_back(model_rd(rd0_addr));
    if (rd1_en) rd1_q.push_back(model_rd(rd1_addr));
    if (hrd) host_q.push_back(model_rd(host_addr));
    if (hacc && host_we && int'(host_addr) < DEPTH) model_mem[host_addr] = host_wdata;
    if (wr_en && int'(wr_addr) < DEPTH) model_mem[wr_addr] = wr_data;
    case (mst)
      M_IDLE:  if (tstart) begin mst = M_RUN; mcnt = 0; end
      M_RUN:   if (wr_en) begin mcnt++; if (mcnt == EW) mst = M_DRAIN; end
      default: mst = M_IDLE;
    endcase
    last_hacc = hacc;
    @(posedge clk);
    @(negedge clk);
    if (rd0_q.size() > 0) exp_rd0 = rd0_q.pop_front();
    if (rd1_q.size() > 0) exp_rd1 = rd1_q.pop_front();
    chk("rd0_data", rd0_data, exp_rd0);
    chk("rd1_data", rd1_data, exp_rd1);
    chk("host_rvalid", host_rvalid, hrd);
    if (host_rvalid) begin
      chk("host_q_nonempty", host_q.size() != 0, 1);
      if (host_q.size() != 0) exp_hrd = host_q.pop_front();
      $display("host read data=%0h exp=%0h", host_rdata, exp_hrd);
    end
    chk("host_rdata", host_rdata, exp_hrd);
    chk("busy", busy, mst != M_IDLE);
    chk("done", done, mst == M_DRAIN);
    chk("host_ready", host_ready, mst == M_IDLE);
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    #1;
    chk("rst_rd0", rd0_data, 0);
    chk("rst_rd1", rd1_data, 0);
    chk("rst_hrdata", host_rdata, 0);
    chk("rst_hrvalid", host_rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hready", host_ready, 1);
    mst = M_IDLE; mcnt = 0;
    rd0_q.delete(); rd1_q.delete(); host_q.delete();
    exp_rd0 = '0; exp_rd1 = '0; exp_hrd = '0;
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_valid = 1; host_we = 1; host_addr = a; host_wdata = d;
    step();
    host_valid = 0; host_we = 0;
    $display("host write addr=%0d data=%0h", a, d);
  endtask

  task automatic host_rd(input logic [AW-1:0] a);
    host_valid = 1; host_we = 0; host_addr = a;
    step();
    host_valid = 0;
  endtask

  task automatic kwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return AW'(100 + $urandom_range(0, 27));
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 16; i++) host_wr(AW'(i), DW'(32'h100 + i));
    host_wr(7'd3, 32'h33);

    // Memory survives reset; a read of address 3 appears only after an edge.
    @(negedge clk);
    do_reset();
    rd0_en = 1; rd0_addr = 7'd3;
    #1;
    chk("rd0_before_edge", rd0_data, 0);
    step();
    rd0_en = 0;
    step();

    // Host preload then dual kernel read.
    host_wr(7'd0, 32'd5);
    host_wr(7'd1, 32'd100);
    rd0_en = 1; rd0_addr = 7'd0; rd1_en = 1; rd1_addr = 7'd1;
    step();
    idle_inputs();
    step();

    // Full run, then dump.
    tstart = 1;
    step();
    tstart = 0;
    for (int i = 0; i < 4; i++) kwrite(AW'(i), DW'(105 + 2 * i));
    step();
    for (int i = 0; i < 4; i++) host_rd(AW'(i));
    step();

    // Host read held during a run; must complete exactly once after IDLE.
    tstart = 1;
    step();
    tstart = 0;
    host_valid = 1; host_we = 0; host_addr = 7'd2;
    repeat (2) step();
    for (int i = 0; i < 4; i++) kwrite(AW'(8 + i), DW'(32'h200 + i));
    begin
      int guard = 0;
      do begin step(); guard++; end while (!last_hacc && guard < 20);
      chk("blocked_read_accepted", last_hacc, 1);
    end
    host_valid = 0;
    repeat (2) step();

    // tstart together with a host write in IDLE.
    tstart = 1; host_valid = 1; host_we = 1; host_addr = 7'd12; host_wdata = 32'habc;
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) kwrite(AW'(13), DW'(i));
    step();
    host_rd(7'd12);
    step();

    // Read-during-write and an out-of-range write that still counts.
    host_wr(7'd7, 32'd9);
    tstart = 1;
    step();
    tstart = 0;
    kwrite(7'd127, 32'hdead);
    rd0_en = 1; rd0_addr = 7'd7;
    kwrite(7'd7, 32'd42);
    kwrite(7'd14, 32'h14);
    rd0_en = 0;
    kwrite(7'd15, 32'h15);
    step();
    rd0_en = 1; rd0_addr = 7'd7; rd1_en = 1; rd1_addr = 7'd127;
    step();
    idle_inputs();
    step();

    // Host and kernel write to the same address in one cycle: kernel wins.
    host_valid = 1; host_we = 1; host_addr = 7'd5; host_wdata = 32'h1111;
    wr_en = 1; wr_addr = 7'd5; wr_data = 32'h2222;
    step();
    idle_inputs();
    host_rd(7'd5);
    step();

    // Reset in the middle of a run aborts it.
    tstart = 1;
    step();
    tstart = 0;
    kwrite(7'd0, 32'h70);
    kwrite(7'd1, 32'h71);
    do_reset();
    repeat (2) step();
    tstart = 1;
    step();
    tstart = 0;
    for (int i = 0; i < 4; i++) kwrite(AW'(i), DW'(32'h80 + i));
    repeat (2) step();

    // Random mix of all ports.
    for (int n = 0; n < 200; n++) begin
      tstart     = ($urandom_range(0, 9) == 0);
      rd0_en     = $urandom_range(0, 1); rd0_addr = rand_addr();
      rd1_en     = $urandom_range(0, 1); rd1_addr = rand_addr();
      wr_en      = ($urandom_range(0, 2) == 0); wr_addr = rand_addr(); wr_data = $urandom;
      host_valid = $urandom_range(0, 1); host_we = $urandom_range(0, 1);
      host_addr  = rand_addr(); host_wdata = $urandom;
      step();
    end
    idle_inputs();
    repeat (8) step();
    chk("host_q_drained", host_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
